// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO result registers.
// Start/Busy/Done handshake; fixed latency of WIDTH+2 cycles from Start to Done.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       hi_lo_we,
   input  logic [WIDTH-1:0] hi_lo_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [1:0]         op_reg;
   logic               sign_a_reg, sign_b_reg, b_zero_reg;
   logic [WIDTH-1:0]   m_reg;
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic               done_reg, div_zero_reg;
   logic [WIDTH-1:0]   hi_reg, lo_reg;

   logic               is_div, is_signed, signs_differ;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     add_sum, shifted, trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   // Signed magnitudes: -2^(W-1) maps onto itself, which reads correctly as unsigned.
   assign abs_a = (!op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign abs_b = (!op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;

   assign is_div       = op_reg[1];
   assign is_signed    = ~op_reg[0];
   assign signs_differ = is_signed & (sign_a_reg ^ sign_b_reg);

   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;
   assign div_zero = div_zero_reg;
   assign hi       = hi_reg;
   assign lo       = lo_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
   always_comb begin
      add_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? m_reg : {WIDTH{1'b0}})};
      shifted = acc_reg[2*WIDTH-1:WIDTH-1];
      trial   = shifted - {1'b0, m_reg};
      acc_next = {add_sum, acc_reg[WIDTH-1:1]};
      if (is_div) begin
         if (!trial[WIDTH])
            acc_next = {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
         else
            acc_next = {shifted[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      prod_fix = signs_differ ? (~acc_reg + 1'b1) : acc_reg;
      quot_fix = signs_differ ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
      rem_fix  = (is_signed && sign_a_reg) ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                                           : acc_reg[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         op_reg       <= '0;
         sign_a_reg   <= 1'b0;
         sign_b_reg   <= 1'b0;
         b_zero_reg   <= 1'b0;
         m_reg        <= '0;
         acc_reg      <= '0;
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
      end else begin
         state_reg <= state_next;
         done_reg  <= (state_reg == FIX);
         case (state_reg)
            IDLE: begin
               if (hi_lo_we[1]) hi_reg <= hi_lo_in;
               if (hi_lo_we[0]) lo_reg <= hi_lo_in;
               if (start) begin
                  op_reg       <= op;
                  sign_a_reg   <= a[WIDTH-1];
                  sign_b_reg   <= b[WIDTH-1];
                  b_zero_reg   <= (b == '0);
                  div_zero_reg <= 1'b0;
                  cnt_reg      <= '0;
                  m_reg        <= op[1] ? abs_b : abs_a;
                  acc_reg      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
               end
            end
            RUN: begin
               acc_reg <= acc_next;
               cnt_reg <= cnt_reg + 1'b1;
            end
            FIX: begin
               if (!is_div) begin
                  hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_reg <= prod_fix[WIDTH-1:0];
               end else if (b_zero_reg) begin
                  div_zero_reg <= 1'b1;
               end else begin
                  hi_reg <= rem_fix;
                  lo_reg <= quot_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32): vector table plus hand-written
// sequences for back-to-back, divide-by-zero, busy-time writes and mid-op reset.
module tb_mult_div_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [1:0]    op, hi_lo_we;
   logic [W-1:0]  a, b, hi_lo_in;
   logic          busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_lo_we(hi_lo_we), .hi_lo_in(hi_lo_in),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      logic         dz;
      string        name;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at the negedge of cycle 0; returns at the negedge of cycle 1.
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = '0; b = '0; op = 2'b00;
   endtask

   // Returns at the negedge of the Done cycle (or after the cycle budget).
   task automatic wait_done(input string name, input int c0, input logic [W-1:0] eh,
                            input logic [W-1:0] el, input logic edz);
      int c = c0;
      bit busy_ok = 1'b1;
      while (!done && c < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         c++;
      end
      chk({name, " done_cycle"}, 64'(c), 64'd34);
      chk({name, " busy_1..33"}, 64'(busy_ok), 64'd1);
      chk({name, " busy_at_done"}, 64'(busy), 64'd0);
      chk({name, " hi"}, 64'(hi), 64'(eh));
      chk({name, " lo"}, 64'(lo), 64'(el));
      chk({name, " div_zero"}, 64'(div_zero), 64'(edz));
      $display("op %s: cycle=%0d hi=0x%08h lo=0x%08h dz=%0b", name, c, hi, lo, div_zero);
   endtask

   initial begin
      vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m3x7"};
      vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
      vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7d2"};
      vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_min_m1"};
      vecs[4] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100d7"};
      vecs[5] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "multu_2p32"};
      vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, "div_7dm2"};
      vecs[7] = '{2'b11, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0, "divu_5d10"};
      vecs[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_min_sq"};
      vecs[9] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd0,        32'd4,        1'b0, "div_m8dm2"};

      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; hi_lo_we = '0; hi_lo_in = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset div_zero", 64'(div_zero), 64'd0);
      @(negedge clk);

      foreach (vecs[i]) begin
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(vecs[i].name, 1, vecs[i].hi, vecs[i].lo, vecs[i].dz);
         @(negedge clk);
         chk({vecs[i].name, " done_single"}, 64'(done), 64'd0);
      end

      // Back-to-back: second Start issued in the Done cycle of the first.
      start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done("b2b_multu", 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done("b2b_mult", 1, 32'h00000000, 32'h00000001, 1'b0);
      @(negedge clk);

      // Preload Hi/Lo, then divide by zero leaves them untouched.
      hi_lo_we = 2'b10; hi_lo_in = 32'h11;
      @(negedge clk);
      hi_lo_we = 2'b01; hi_lo_in = 32'h22;
      @(negedge clk);
      hi_lo_we = 2'b00;
      chk("preload hi", 64'(hi), 64'h11);
      chk("preload lo", 64'(lo), 64'h22);
      start_op(2'b11, 32'd100, 32'd0);
      wait_done("divu_by0", 1, 32'h11, 32'h22, 1'b1);
      @(negedge clk);
      chk("dz_held", 64'(div_zero), 64'd1);
      start_op(2'b01, 32'd2, 32'd3);
      chk("dz_cleared", 64'(div_zero), 64'd0);
      wait_done("multu_2x3", 1, 32'd0, 32'd6, 1'b0);
      @(negedge clk);

      // Start and HiLoWe during Busy are ignored.
      start_op(2'b11, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3; hi_lo_we = 2'b11; hi_lo_in = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; hi_lo_we = 2'b00; hi_lo_in = '0;
      wait_done("divu_busy_ign", 6, 32'd2, 32'd14, 1'b0);
      begin
         int extra = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) extra++;
         end
         chk("divu_busy_ign extra_done", 64'(extra), 64'd0);
      end

      // Reset at cycle 10 of a MULT aborts with no Done.
      start_op(2'b00, 32'd12345, 32'd678);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort hi", 64'(hi), 64'd0);
      chk("abort lo", 64'(lo), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      begin
         int seen = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("abort no_done", 64'(seen), 64'd0);
      end
      $display("op reset_abort: hi=0x%08h lo=0x%08h busy=%0b", hi, lo, busy);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
